pc_gen_unit: RTL

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

---
 rtl/pc_gen_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_gen_unit.sv
// Program-counter generator for instruction fetch: boot/run/halt control,
// sequential advance on accepted fetches, and exception/branch redirection.
module pc_gen_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_vld,
    input  logic              pc_rdy,
    input  logic              redir_vld,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              exc_vld,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [31:0]       fire_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(PC_STEP - ADDR_W'(1));

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_vld_q, pc_vld_d;
    logic              halted_q, halted_d;
    logic [31:0]       fire_cnt_q, fire_cnt_d;

    logic              fire_s;
    logic              redir_any_s;
    logic [ADDR_W-1:0] redir_tgt_s;

    // Next-state, next-pc and fire counter computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fire_cnt_d  = fire_cnt_q;
        fire_s      = pc_vld_q && pc_rdy;
        redir_any_s = exc_vld || redir_vld;
        if (exc_vld) begin
            redir_tgt_s = align_addr(exc_pc);
        end else begin
            redir_tgt_s = align_addr(redir_pc);
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VEC;
            end
            ST_RUN: begin
                // Redirects win over halt; an unfired address is simply replaced.
                if (redir_any_s) begin
                    pc_d = redir_tgt_s;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (fire_s) begin
                    pc_d = pc_q + PC_STEP;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HALT: begin
                if (redir_any_s) begin
                    state_d = ST_RUN;
                    pc_d    = redir_tgt_s;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase

        if (fire_s) begin
            fire_cnt_d = fire_cnt_q + 32'd1;
        end else begin
            fire_cnt_d = fire_cnt_q;
        end

        pc_vld_d = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pc_vld_q   <= 1'b0;
            halted_q   <= 1'b0;
            fire_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_vld_q   <= pc_vld_d;
            halted_q   <= halted_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign pc_vld   = pc_vld_q;
    assign halted   = halted_q;
    assign fire_cnt = fire_cnt_q;

endmodule

// Invariant checker for pc_gen_unit outputs; instantiated alongside the unit.
module pc_gen_unit_chk (
    input logic        clk,
    input logic        rst,
    input logic        pc_vld,
    input logic        halted,
    input logic [31:0] fire_cnt
);

    logic seen_rst_q;
    logic rst_prev_q;

    // Track whether reset has ever been applied and whether it was applied last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_rst_q <= 1'b1;
            rst_prev_q <= 1'b1;
        end else begin
            seen_rst_q <= seen_rst_q;
            rst_prev_q <= 1'b0;
        end
    end

    // Halted and valid are mutually exclusive; reset leaves an idle, zero-count unit.
    always @(negedge clk) begin
        if (seen_rst_q) begin
            a_halt_excl: assert (!(halted && pc_vld));
            if (rst_prev_q) begin
                a_rst_state: assert (!pc_vld && !halted && (fire_cnt == 32'd0));
            end
        end
    end

endmodule
